tx_sr: RTL

//  CAN transmit serializer, the counterpart of the receive shift register.
//  - Captures a parallel word and drives it MSB-first onto can_bus_tx, one bit per tx_enable strobe.
//  - Inserts CAN stuff bits and reports completion with a one-cycle tx_done pulse.
//  - tx_enable is the bit-time strobe from the bit-timing logic; the same strobe clocks the receive side.

---
 rtl/tx_sr.sv | 94 +++++++++
 1 files changed

// File: rtl/tx_sr.sv
// tx_sr: CAN transmit serializer, MSB-first with optional bit stuffing, one bit per tx_enable strobe.
module tx_sr #(
  parameter int NUM_BITS = 32,
  parameter int STUFF_EN = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tx_load,
  input  logic [NUM_BITS-1:0] tx_data,
  input  logic                tx_enable,
  output logic                can_bus_tx,
  output logic                tx_busy,
  output logic                stuff_bit,
  output logic                tx_done
);
  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] LAST = CW'(NUM_BITS - 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_BITS);
  typedef enum logic [1:0] {IDLE, SHIFT, STUFF, DONE} state_t;
  state_t state, state_n;
  logic [NUM_BITS-1:0] shreg, shreg_n, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] run, run_n;
  logic last, last_n, bus_n, stuff_n, b, fin, stf_go;
  assign nxt = shreg << 1;
  assign b = nxt[NUM_BITS-1];
  assign fin = (state == SHIFT) ? cnt == LAST : cnt == FULL;
  // Stuffing is decided only when a data bit ends; a stuff bit never completes a run of five.
  assign stf_go = state == SHIFT && STUFF_EN != 0 && run == 3'd5;
  assign tx_busy = state == SHIFT || state == STUFF;
  assign tx_done = state == DONE;
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    cnt_n = cnt;
    run_n = run;
    last_n = last;
    bus_n = can_bus_tx;
    stuff_n = stuff_bit;
    case (state)
      IDLE: if (tx_load) begin
        shreg_n = tx_data;
        bus_n = tx_data[NUM_BITS-1];
        last_n = tx_data[NUM_BITS-1];
        run_n = 3'd1;
        cnt_n = '0;
        state_n = SHIFT;
      end
      SHIFT, STUFF: if (tx_enable) begin
        stuff_n = 1'b0;
        if (state == SHIFT) cnt_n = cnt + 1'b1;
        if (stf_go) begin
          bus_n = ~last;
          stuff_n = 1'b1;
          last_n = ~last;
          run_n = 3'd1;
          state_n = STUFF;
        end else if (fin) begin
          bus_n = 1'b1;
          state_n = DONE;
        end else begin
          shreg_n = nxt;
          bus_n = b;
          run_n = (b == last) ? run + 3'd1 : 3'd1;
          last_n = b;
          state_n = SHIFT;
        end
      end
      default: begin
        bus_n = 1'b1;
        state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      cnt <= '0;
      run <= '0;
      last <= 1'b0;
      can_bus_tx <= 1'b1;
      stuff_bit <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      cnt <= cnt_n;
      run <= run_n;
      last <= last_n;
      can_bus_tx <= bus_n;
      stuff_bit <= stuff_n;
    end
  end
endmodule
